rom_reader: RTL

- Initiator-side controller for the 16-entry seven-segment ROM. The ROM takes `addr` and `ena` and returns the 7-bit pattern plus an echoed address.
- Walks a programmable address range, drives `rom_addr`/`rom_ena`, and waits the ROM read latency.
- Captures each pattern with its echoed address and checks the echo against the issued address.
- Presents each word downstream (display/scan logic) on a valid/ready handshake.

---
 rtl/rom_pkg.sv | 56 +++++
 rtl/rom_reader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rom_pkg.sv
// Shared types and constants for the seven-segment ROM, its reader and the bench.
package rom_pkg;

    localparam int unsigned ROM_ADDR_W = 4;
    localparam int unsigned ROM_DATA_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        DONE
    } state_e;

    // Active-low segments, bit order gfedcba.
    localparam logic [ROM_DATA_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [ROM_DATA_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [ROM_DATA_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [ROM_DATA_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [ROM_DATA_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [ROM_DATA_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [ROM_DATA_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [ROM_DATA_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [ROM_DATA_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [ROM_DATA_W-1:0] SEG_9 = 7'b0010000;
    localparam logic [ROM_DATA_W-1:0] SEG_A = 7'b0001000;
    localparam logic [ROM_DATA_W-1:0] SEG_B = 7'b0000011;
    localparam logic [ROM_DATA_W-1:0] SEG_C = 7'b1000110;
    localparam logic [ROM_DATA_W-1:0] SEG_D = 7'b0100001;
    localparam logic [ROM_DATA_W-1:0] SEG_E = 7'b0000110;
    localparam logic [ROM_DATA_W-1:0] SEG_F = 7'b0001110;

    function automatic logic [ROM_DATA_W-1:0] seg_of(input logic [ROM_ADDR_W-1:0] hex);
        logic [ROM_DATA_W-1:0] seg;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/rom_reader.sv
// Sweeps an address range of the segment ROM, waits its read latency, checks the
// echoed address and hands each word downstream on a valid/ready handshake.
module rom_reader
    import rom_pkg::*;
#(
    parameter int unsigned ADDR_W     = ROM_ADDR_W,
    parameter int unsigned DATA_W     = ROM_DATA_W,
    parameter int unsigned FIRST_ADDR = 0,
    parameter int unsigned LAST_ADDR  = 15,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned CONTINUOUS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ena,
    input  logic [DATA_W-1:0] rom_data,
    input  logic [ADDR_W-1:0] rom_addr_out,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              addr_err
);

    localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_cnt_q  <= '0;
            rom_addr_q  <= '0;
            lat_cnt_q   <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            rom_addr_q  <= rom_addr_d;
            lat_cnt_q   <= lat_cnt_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    // rom_addr only moves together with entry to ISSUE, so the ROM never sees a
    // fresh address outside the enable cycle.
    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        rom_addr_d  = rom_addr_q;
        lat_cnt_d   = lat_cnt_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;

        if (abort) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_cnt_d = FIRST;
                        rom_addr_d = FIRST;
                        err_d      = 1'b0;
                        state_d    = ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt_d = LAT_W'(READ_LAT - 1);
                    state_d   = WAIT;
                end
                WAIT: begin
                    if (lat_cnt_q == '0) begin
                        out_data_d  = rom_data;
                        out_addr_d  = rom_addr_out;
                        out_valid_d = 1'b1;
                        if (rom_addr_out != addr_cnt_q) begin
                            err_d = 1'b1;
                        end
                        state_d = HOLD;
                    end else begin
                        lat_cnt_d = lat_cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (addr_cnt_q != LAST) begin
                            addr_cnt_d = addr_cnt_q + 1'b1;
                            rom_addr_d = addr_cnt_q + 1'b1;
                            state_d    = ISSUE;
                        end else if (CONTINUOUS != 0) begin
                            addr_cnt_d = FIRST;
                            rom_addr_d = FIRST;
                            state_d    = ISSUE;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rom_ena   = (state_q == ISSUE);
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign addr_err  = err_q;

endmodule
